// File: rtl/mux4_scan_ctrl_if.sv
// mux4_scan_ctrl_if: scan request, mux feedback and result bus of the 4-channel scan sequencer
// Signals: start (scan request), y_in (mux output), selection (mux select),
//          busy (scan in progress), done (one-cycle completion strobe), result (4 captured samples)
interface mux4_scan_ctrl_if;
    logic       start;
    logic       y_in;
    logic [1:0] selection;
    logic       busy;
    logic       done;
    logic [3:0] result;
    modport master (output start, y_in, input selection, busy, done, result);
    modport slave (input start, y_in, output selection, busy, done, result);
endinterface

// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: steps a 4:1 mux through channels 0..3, samples y per channel, reports a 4-bit result
// Ports: clk (rising edge), rst (synchronous, active high), bus (slave side of mux4_scan_ctrl_if):
//        start in, y_in in, selection out, busy out, done out, result out.
// Parameter DWELL (1..255): cycles each channel is held before its sample is taken.
// Optional macro MUX4_SCAN_AUTO_RESTART_EN: start seen in DONE launches the next scan immediately.
module mux4_scan_ctrl #(
    parameter int DWELL = 2
) (
    input logic            clk,
    input logic            rst,
    mux4_scan_ctrl_if.slave bus
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t          st, nxt;
    logic [1:0]      ch;
    logic [CW-1:0]   cnt;
    logic [2:0]      shadow;
    logic [3:0]      result;
    logic            last;
    logic            go;
    // last dwell cycle of the current channel: this edge takes the sample
    assign last = cnt == CW'(DWELL - 1);
`ifdef MUX4_SCAN_AUTO_RESTART_EN
    assign go = bus.start && (st == IDLE || st == DONE);
`else
    assign go = bus.start && st == IDLE;
`endif
    always_comb begin
        nxt = IDLE;
        nxt = go ? SCAN : st != SCAN ? IDLE : (last && ch == 2'd3) ? DONE : SCAN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            ch     <= 2'd0;
            cnt    <= '0;
            shadow <= 3'd0;
            result <= 4'd0;
        end else begin
            st <= nxt;
            if (go) begin
                ch  <= 2'd0;
                cnt <= '0;
            end else if (st == SCAN) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    // channels 0..2 park in shadow so result updates only once, on the final capture
                    if (ch != 2'd3) begin
                        shadow[ch] <= bus.y_in;
                        ch         <= ch + 1'b1;
                    end else begin
                        result <= {bus.y_in, shadow};
                        ch     <= 2'd0;
                    end
                end
            end
        end
    end
    assign bus.selection = ch;
    assign bus.busy      = st == SCAN;
    assign bus.done      = st == DONE;
    assign bus.result    = result;
endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// tb_mux4_scan_ctrl: checks three sequencers (DWELL 1, 2, 3) against a timing-rule reference model
module tb_mux4_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done = 0;
    logic       st   [1:3];
    logic [3:0] ab   [1:3];
    logic [1:0] sel  [1:3];
    logic       bz   [1:3];
    logic       dn   [1:3];
    logic [3:0] res  [1:3];
    logic [3:0] prev [1:3];
    always @(posedge clk) cyc <= cyc + 1;
    // DUT k has DWELL=k; its y_in is a 4:1 mux over ab[k] steered by its own selection
    for (genvar g = 1; g <= 3; g++) begin : d
        mux4_scan_ctrl_if b ();
        assign b.start = st[g];
        assign b.y_in  = ab[g][b.selection];
        assign sel[g]  = b.selection;
        assign bz[g]   = b.busy;
        assign dn[g]   = b.done;
        assign res[g]  = b.result;
        mux4_scan_ctrl #(.DWELL(g)) u (.clk(clk), .rst(rst), .bus(b.slave));
    end
    // One full scan on DUT k. E0 is the edge that samples start; cycle c is the one after edge E0+c.
    // Expected: busy and selection=c/k for c<4k, done alone at c=4k, bit i = mux input i present at edge E0+(i+1)k.
    // mode 0 static inputs, 1 random inputs every cycle, 2 toggle input 2 on at ch2's first cycle and off after its sample.
    task automatic run_scan(input int k, input bit hold, input int mode, input bit chained);
        logic [3:0] expr;
        logic [3:0] er;
        logic [1:0] es;
        logic       eb;
        logic       ed;
        int         n;
        n = 4 * k;
        expr = 4'd0;
        if (!chained) begin
            @(negedge clk);
            st[k] = 1'b1;
        end
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            eb = c < n;
            ed = c == n;
            es = c < n ? 2'(c / k) : 2'd0;
            er = c < n ? prev[k] : expr;
            checks++;
            if ({bz[k], dn[k], sel[k], res[k]} !== {eb, ed, es, er}) begin
                errors++;
                $display("FAIL scan D=%0d c=%0d busy/done/sel/result got %b %b %b %b want %b %b %b %b",
                         k, c, bz[k], dn[k], sel[k], res[k], eb, ed, es, er);
            end
            if (!hold) st[k] = 1'b0;
            if (mode == 1) ab[k] = 4'($urandom);
            if (mode == 2 && c == 2 * k) ab[k][2] = 1'b1;
            if (mode == 2 && c == 3 * k) ab[k][2] = 1'b0;
            if ((c + 1) % k == 0 && c < n) expr[(c + 1) / k - 1] = ab[k][(c + 1) / k - 1];
        end
        prev[k] = expr;
        last_done = cyc;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 1; k <= 3; k++) begin
                checks++;
                if ({bz[k], dn[k], sel[k], res[k]} !== 8'd0) begin
                    errors++;
                    $display("FAIL reset_idle D=%0d c=%0d busy/done/sel/result got %b %b %b %b want all zero",
                             k, c, bz[k], dn[k], sel[k], res[k]);
                end
            end
        end
    endtask
    task automatic test_directed();
        ab[2] = 4'b1010;
        run_scan(2, 1'b0, 0, 1'b0);
        checks++;
        if (res[2] !== 4'b1010) begin
            errors++;
            $display("FAIL directed_d2 result got %b want 1010", res[2]);
        end
        ab[1] = 4'b0000;
        run_scan(1, 1'b0, 0, 1'b0);
        checks++;
        if (res[1] !== 4'b0000) begin
            errors++;
            $display("FAIL directed_d1_a result got %b want 0000", res[1]);
        end
        ab[1] = 4'b0111;
        run_scan(1, 1'b0, 0, 1'b0);
        checks++;
        if (res[1] !== 4'b0111) begin
            errors++;
            $display("FAIL directed_d1_b result got %b want 0111", res[1]);
        end
    endtask
    task automatic test_late_toggle();
        ab[3] = 4'b0000;
        run_scan(3, 1'b0, 2, 1'b0);
        checks++;
        if (res[3] !== 4'b0100) begin
            errors++;
            $display("FAIL late_toggle result got %b want 0100", res[3]);
        end
    endtask
    task automatic test_back_to_back();
        int t;
        int want;
        ab[2] = 4'($urandom);
        run_scan(2, 1'b1, 1, 1'b0);
        t = last_done;
`ifdef MUX4_SCAN_AUTO_RESTART_EN
        want = 9;
        run_scan(2, 1'b1, 1, 1'b1);
        checks++;
        if (last_done - t !== want) begin
            errors++;
            $display("FAIL restart_spacing got %0d want %0d", last_done - t, want);
        end
        t = last_done;
        run_scan(2, 1'b0, 1, 1'b1);
`else
        want = 10;
        @(negedge clk);
        checks++;
        if ({bz[2], dn[2], sel[2]} !== 4'd0) begin
            errors++;
            $display("FAIL held_idle busy/done/sel got %b %b %b want 0 0 00", bz[2], dn[2], sel[2]);
        end
        run_scan(2, 1'b0, 1, 1'b1);
`endif
        checks++;
        if (last_done - t !== want) begin
            errors++;
            $display("FAIL done_spacing got %0d want %0d", last_done - t, want);
        end
        @(negedge clk);
        checks++;
        if ({bz[2], dn[2], sel[2]} !== 4'd0) begin
            errors++;
            $display("FAIL back_to_back_idle busy/done/sel got %b %b %b want 0 0 00", bz[2], dn[2], sel[2]);
        end
    endtask
    task automatic test_reset_mid();
        @(negedge clk);
        st[2] = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            st[2] = 1'b0;
        end
        checks++;
        if ({bz[2], sel[2]} !== 3'b110) begin
            errors++;
            $display("FAIL reset_mid_pre busy/sel got %b %b want 1 10", bz[2], sel[2]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) prev[k] = 4'd0;
        checks++;
        if ({bz[2], dn[2], sel[2], res[2]} !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid busy/done/sel/result got %b %b %b %b want all zero",
                     bz[2], dn[2], sel[2], res[2]);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if ({bz[2], dn[2]} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_nodone c=%0d busy/done got %b %b want 0 0", c, bz[2], dn[2]);
            end
        end
    endtask
    task automatic test_random();
        int gap;
        for (int it = 0; it < 8; it++) begin
            for (int k = 1; k <= 3; k++) begin
                gap = int'($urandom_range(3, 0));
                for (int c = 0; c < gap; c++) begin
                    @(negedge clk);
                    checks++;
                    if ({bz[k], dn[k], res[k]} !== {2'b00, prev[k]}) begin
                        errors++;
                        $display("FAIL random_idle D=%0d busy/done/result got %b %b %b want 0 0 %b",
                                 k, bz[k], dn[k], res[k], prev[k]);
                    end
                end
                ab[k] = 4'($urandom);
                run_scan(k, 1'b0, 1, 1'b0);
            end
        end
    endtask
    initial begin
        for (int k = 1; k <= 3; k++) begin
            st[k]   = 1'b0;
            ab[k]   = 4'd0;
            prev[k] = 4'd0;
        end
        test_reset();
        test_directed();
        test_late_toggle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
